axi_read: RTL and testbench
===========================

AXI_READ -- requirements
Module: axi_read

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_1000, byte address of register 0.
REQ-002 The block SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (power of two, 2..256).
REQ-003 The block SHALL have parameter TIMEOUT, default 8, maximum WAIT cycles before error (1..255).
REQ-004 Port axi_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port ARADDR  input  32  read address.
REQ-007 Port ARVALID  input  1  read address valid.
REQ-008 Port ARREADY  output  1  read address ready.
REQ-009 Port RDATA  output  32  read data.
REQ-010 Port RRESP  output  2  read response.
REQ-011 Port RVALID  output  1  read data valid.
REQ-012 Port RREADY  input  1  read data ready.
REQ-013 Port rd_req  output  1  register-bank read request, level.
REQ-014 Port rd_addr  output  clog2(NUM_REGS)  register word index.
REQ-015 Port rd_data_in  input  32  register-bank read data, valid with rd_ack.
REQ-016 Port rd_ack  input  1  register-bank acknowledge, single cycle.

Function
REQ-017 The block SHALL implement states IDLE, WAIT, RESP in a single state register.
REQ-018 ARREADY SHALL be registered: set to 1 at the first edge in IDLE, cleared at the edge where ARVALID && ARREADY is sampled high.
REQ-019 On an AR handshake the block SHALL capture ARADDR and classify it:
  - in range and aligned: ARADDR >= BASE_ADDR, < BASE_ADDR+4*NUM_REGS, ARADDR[1:0]==0;
  - out of range: RESP with RRESP=2'b11 (DECERR);
  - in range but misaligned: RESP with RRESP=2'b10 (SLVERR);
  - neither error case drives rd_req.
REQ-020 For a valid address the block SHALL enter WAIT with rd_addr=(ARADDR-BASE_ADDR)>>2; rd_req and rd_addr SHALL be registered and held constant for all of WAIT.
REQ-021 In WAIT the block SHALL count cycles in a saturating counter cleared on WAIT entry.
REQ-022 rd_ack sampled high in WAIT SHALL capture rd_data_in into RDATA, set RRESP=2'b00, drop rd_req, and move to RESP at that edge.
REQ-023 If rd_ack is not seen within TIMEOUT WAIT cycles, the block SHALL move to RESP with RRESP=2'b10 and RDATA=0, dropping rd_req.
REQ-024 rd_ack in the final WAIT cycle SHALL win over timeout; rd_ack outside WAIT SHALL be ignored.
REQ-025 Latency with zero-wait ack: AR handshake at edge N, rd_req high after N, ack sampled at N+1, RVALID high after N+1.
REQ-026 In RESP, RVALID SHALL be 1 and RDATA/RRESP SHALL hold stable until RREADY is sampled high.
REQ-027 After that edge, RVALID SHALL go to 0, the block SHALL return to IDLE, and ARREADY SHALL rise one edge later.
REQ-028 For error responses RDATA SHALL be 32'h0.
REQ-029 Only one outstanding read SHALL exist; ARREADY SHALL stay 0 outside IDLE.

Reset
REQ-030 While rst is high at an edge, state SHALL become IDLE and outputs SHALL clear: ARREADY=0, RVALID=0, RRESP=2'b00, RDATA=0, rd_req=0, rd_addr=0, counter=0.
REQ-031 Reset mid-transaction (WAIT or RESP) SHALL abandon it with no response; ARREADY SHALL rise at the first edge after rst deasserts.

Verification
REQ-032 ARADDR=0x1008 accepted, rd_ack one cycle after rd_req with rd_data_in=0xDEADBEEF, RREADY=1 -> rd_addr=2, RDATA=0xDEADBEEF, RRESP=00, RVALID exactly one cycle.
REQ-033 ARADDR=0x2000 -> rd_req never asserts, RVALID with RRESP=11, RDATA=0.
REQ-034 ARADDR=0x1006 -> rd_req never asserts, RRESP=10, RDATA=0.
REQ-035 ARADDR=0x1004 with rd_ack held low -> rd_req high exactly 8 cycles, then RRESP=10, RDATA=0; rd_ack in the 8th cycle instead -> RRESP=00 with ack data.
REQ-036 RREADY held low 5 cycles in RESP, second ARVALID pending -> RVALID, RDATA, RRESP stable; ARREADY=0 until one edge after the RREADY handshake.
REQ-037 rst pulsed during WAIT -> next edge rd_req=0, RVALID=0; late rd_ack ignored; a new read then completes normally.

Source files
------------

// File: rtl/axi_read.sv
// AXI4-Lite read-only slave front end: accepts one read at a time, decodes it
// against a word-addressed register bank and returns the bank data or an error.
module axi_read #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          NUM_REGS  = 16,
    parameter int          TIMEOUT   = 8
) (
    input  logic                        axi_clk,
    input  logic                        rst,
    input  logic [31:0]                 ARADDR,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [31:0]                 RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic                        rd_req,
    output logic [$clog2(NUM_REGS)-1:0] rd_addr,
    input  logic [31:0]                 rd_data_in,
    input  logic                        rd_ack
);

    localparam int          AW       = $clog2(NUM_REGS);
    localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + (33'(NUM_REGS) << 2);
    localparam logic [7:0]  LAST_CNT = 8'(TIMEOUT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rd_req_q, rd_req_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;

    logic ar_fire;
    logic in_range;
    logic addr_ok;
    logic timeout_hit;

    // 33-bit compares so a window ending at the top of the 4 GB map cannot wrap
    assign ar_fire     = ARVALID && arready_q;
    assign in_range    = ({1'b0, ARADDR} >= {1'b0, BASE_ADDR}) && ({1'b0, ARADDR} < ADDR_END);
    assign addr_ok     = in_range && (ARADDR[1:0] == 2'b00);
    assign timeout_hit = (wait_cnt_q == LAST_CNT);

    always_ff @(posedge axi_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            rresp_q    <= RESP_OKAY;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            wait_cnt_q <= 8'h0;
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ar_fire) state_d = addr_ok ? WAIT : RESP;
            WAIT: if (rd_ack || timeout_hit) state_d = RESP;
            RESP: if (RREADY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_req_d   = rd_req_q;
        rd_addr_d  = rd_addr_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                arready_d = !ar_fire;
                if (ar_fire) begin
                    if (addr_ok) begin
                        rd_req_d   = 1'b1;
                        rd_addr_d  = AW'((ARADDR - BASE_ADDR) >> 2);
                        wait_cnt_d = 8'h0;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = 32'h0;
                        rresp_d  = in_range ? RESP_SLVERR : RESP_DECERR;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
                // an ack in the last counted cycle still wins over the timeout
                if (rd_ack) begin
                    rd_req_d = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = rd_data_in;
                    rresp_d  = RESP_OKAY;
                end else if (timeout_hit) begin
                    rd_req_d = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = 32'h0;
                    rresp_d  = RESP_SLVERR;
                end
            end
            RESP: begin
                if (RREADY) rvalid_d = 1'b0;
            end
            default: begin
                rvalid_d = 1'b0;
                rd_req_d = 1'b0;
            end
        endcase
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign rd_req  = rd_req_q;
    assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_axi_read.sv
// Randomized self-checking bench for axi_read, predicting each read at the
// transaction level: response code, data, register index and request length.
module tb_axi_read;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          NREGS = 16;
   localparam int          TMO   = 8;

   logic        axi_clk;
   logic        rst;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;
   logic        rd_req;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data_in;
   logic        rd_ack;

   int checks;
   int failures;

   axi_read #(
      .BASE_ADDR(BASE),
      .NUM_REGS (NREGS),
      .TIMEOUT  (TMO)
   ) dut (
      .axi_clk   (axi_clk),
      .rst       (rst),
      .ARADDR    (ARADDR),
      .ARVALID   (ARVALID),
      .ARREADY   (ARREADY),
      .RDATA     (RDATA),
      .RRESP     (RRESP),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_data_in(rd_data_in),
      .rd_ack    (rd_ack)
   );

   // Free-running clock; every drive and every sample happens at the falling edge
   initial begin
      axi_clk = 1'b0;
      forever #5 axi_clk = ~axi_clk;
   end

   // Single point of comparison so every check is counted the same way
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model: what one read should produce, from the address map rules alone
   function automatic void predict(input logic [31:0] addr, input int ackDelay,
                                   input logic [31:0] ackData,
                                   output logic [1:0] resp, output logic [31:0] data,
                                   output int reqCycles, output int idx);
      longint a  = longint'(addr);
      longint lo = longint'(BASE);
      longint hi = longint'(BASE) + 4 * NREGS;
      idx = 0;
      if (a < lo || a >= hi) begin
         resp = 2'b11; data = 32'h0; reqCycles = 0;
      end else if (a % 4 != 0) begin
         resp = 2'b10; data = 32'h0; reqCycles = 0;
      end else begin
         idx = int'((a - lo) / 4);
         if (ackDelay < TMO) begin
            resp = 2'b00; data = ackData; reqCycles = ackDelay + 1;
         end else begin
            resp = 2'b10; data = 32'h0; reqCycles = TMO;
         end
      end
   endfunction

   // Called at a falling edge; returns at the falling edge right after the AR handshake
   task automatic waitHandshake(input logic [31:0] addr);
      bit seen = 0;
      ARADDR  = addr;
      ARVALID = 1'b1;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (ARREADY === 1'b1) seen = 1;
         @(negedge axi_clk);
      end
      if (!seen) checkOutput("arreadyWait", 32'd0, 32'd1);
   endtask

   // One complete read: handshake, bank emulation with a chosen ack delay, response drain
   task automatic applyStimulus(input logic [31:0] addr, input int ackDelay,
                                input logic [31:0] ackData, input int rreadyDelay,
                                input bit keepPending);
      logic [1:0]  expResp;
      logic [31:0] expData;
      int          expCycles;
      int          expIdx;
      int          reqCycles = 0;
      bit          done = 0;
      predict(addr, ackDelay, ackData, expResp, expData, expCycles, expIdx);
      waitHandshake(addr);
      ARVALID = keepPending;
      if (keepPending) ARADDR = BASE + 32'h4;
      for (int c = 0; c < 40 && !done; c++) begin
         if (RVALID === 1'b1) begin
            done = 1;
         end else begin
            if (rd_req === 1'b1) begin
               reqCycles++;
               checkOutput("rdAddr", 32'(rd_addr), 32'(expIdx));
               rd_ack     = (reqCycles - 1 == ackDelay);
               rd_data_in = rd_ack ? ackData : $urandom;
            end else begin
               rd_ack     = 1'($urandom_range(0, 1));
               rd_data_in = $urandom;
            end
            @(negedge axi_clk);
         end
      end
      if (!done) checkOutput("rvalidWait", 32'd0, 32'd1);
      checkOutput("reqCycles", 32'(reqCycles), 32'(expCycles));
      checkOutput("rresp", 32'(RRESP), 32'(expResp));
      checkOutput("rdata", RDATA, expData);
      checkOutput("rdReqDone", 32'(rd_req), 32'd0);
      for (int i = 0; i < rreadyDelay; i++) begin
         RREADY     = 1'b0;
         rd_ack     = 1'($urandom_range(0, 1));
         rd_data_in = $urandom;
         @(negedge axi_clk);
         checkOutput("rvalidHold", 32'(RVALID), 32'd1);
         checkOutput("rdataHold", RDATA, expData);
         checkOutput("rrespHold", 32'(RRESP), 32'(expResp));
         checkOutput("arreadyResp", 32'(ARREADY), 32'd0);
      end
      RREADY = 1'b1;
      rd_ack = 1'($urandom_range(0, 1));
      @(negedge axi_clk);
      RREADY = 1'b0;
      rd_ack = 1'b0;
      checkOutput("rvalidDrop", 32'(RVALID), 32'd0);
      checkOutput("arreadyLate", 32'(ARREADY), 32'd0);
      @(negedge axi_clk);
      checkOutput("arreadyBack", 32'(ARREADY), 32'd1);
      if (!keepPending) ARVALID = 1'b0;
   endtask

   // Directed corner cases, a reset during WAIT, then a randomized run
   initial begin
      logic [31:0] addr;
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      ARADDR     = 32'h0;
      ARVALID    = 1'b0;
      RREADY     = 1'b0;
      rd_data_in = 32'h0;
      rd_ack     = 1'b0;
      repeat (2) @(posedge axi_clk);
      @(negedge axi_clk);
      checkOutput("rstArready", 32'(ARREADY), 32'd0);
      checkOutput("rstRvalid", 32'(RVALID), 32'd0);
      checkOutput("rstRresp", 32'(RRESP), 32'd0);
      checkOutput("rstRdata", RDATA, 32'h0);
      checkOutput("rstRdReq", 32'(rd_req), 32'd0);
      checkOutput("rstRdAddr", 32'(rd_addr), 32'd0);
      rst = 1'b0;
      @(negedge axi_clk);
      checkOutput("arreadyAfterRst", 32'(ARREADY), 32'd1);

      applyStimulus(32'h1008, 0,   32'hDEADBEEF, 0, 1'b0);
      applyStimulus(32'h2000, 0,   32'h11111111, 1, 1'b0);
      applyStimulus(32'h1006, 0,   32'h22222222, 0, 1'b0);
      applyStimulus(32'h1004, 100, 32'h33333333, 0, 1'b0);
      applyStimulus(32'h1004, 7,   32'h44444444, 0, 1'b0);
      applyStimulus(32'h1008, 2,   32'h55555555, 5, 1'b1);
      applyStimulus(32'h103C, 1,   32'h66666666, 0, 1'b0);
      applyStimulus(32'h1040, 0,   32'h77777777, 0, 1'b0);
      applyStimulus(32'h0FFC, 0,   32'h88888888, 0, 1'b0);

      waitHandshake(32'h1004);
      ARVALID = 1'b0;
      checkOutput("midRdReq", 32'(rd_req), 32'd1);
      repeat (2) @(negedge axi_clk);
      rst = 1'b1;
      @(negedge axi_clk);
      checkOutput("midRstRdReq", 32'(rd_req), 32'd0);
      checkOutput("midRstRvalid", 32'(RVALID), 32'd0);
      checkOutput("midRstArready", 32'(ARREADY), 32'd0);
      rst        = 1'b0;
      rd_ack     = 1'b1;
      rd_data_in = 32'hBADBAD00;
      @(negedge axi_clk);
      rd_ack = 1'b0;
      checkOutput("lateAckArready", 32'(ARREADY), 32'd1);
      checkOutput("lateAckRvalid", 32'(RVALID), 32'd0);
      checkOutput("lateAckRdReq", 32'(rd_req), 32'd0);
      applyStimulus(32'h1010, 3, 32'hCAFEF00D, 1, 1'b0);

      for (int t = 0; t < 60; t++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: addr = BASE + 32'(4 * $urandom_range(0, NREGS - 1));
            3:       addr = BASE + 32'(4 * $urandom_range(0, NREGS - 1)) + 32'($urandom_range(1, 3));
            4:       addr = BASE + 32'(4 * NREGS) + 32'($urandom_range(0, 80));
            default: addr = BASE - 32'($urandom_range(1, 32));
         endcase
         applyStimulus(addr, int'($urandom_range(0, 10)), $urandom,
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      ARVALID = 1'b0;
      @(negedge axi_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
